// File: rtl/exmem_skid.sv
// EX/MEM pipeline stage with valid/ready handshake and a two-entry skid buffer.
// Head register H drives the MEM-side outputs; skid register S absorbs the one
// extra entry that can arrive in the cycle after MEM deasserts out_ready.
// Ports:
//   clock, rst (async active-low), flush (synchronous discard of held entries)
//   in_valid/in_ready + WB, M, ALUOut, RegRD, WriteDataIn   : entry from EX
//   out_valid/out_ready + WBreg, Mreg, ALUreg, RegRDreg,
//     WriteDataOut                                         : head entry to MEM
//   count                                                  : entries held (0..2)
//   fwd_valid, fwd_rd, fwd_data                            : hazard-unit tap
module exmem_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned WB_W   = 2,
  parameter int unsigned M_W    = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [DATA_W-1:0] ALUOut,
  input  logic [REG_W-1:0]  RegRD,
  input  logic [DATA_W-1:0] WriteDataIn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WBreg,
  output logic [M_W-1:0]    Mreg,
  output logic [DATA_W-1:0] ALUreg,
  output logic [REG_W-1:0]  RegRDreg,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic [1:0]        count,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  // Entry layout (MSB..LSB): WB | M | ALU | RD | WD
  localparam int unsigned WD_LSB  = 0;
  localparam int unsigned RD_LSB  = WD_LSB + DATA_W;
  localparam int unsigned ALU_LSB = RD_LSB + REG_W;
  localparam int unsigned M_LSB   = ALU_LSB + DATA_W;
  localparam int unsigned WB_LSB  = M_LSB + M_W;
  localparam int unsigned ENT_W   = WB_LSB + WB_W;

  logic [ENT_W-1:0] r_h;
  logic [ENT_W-1:0] r_s;
  logic             r_h_valid;
  logic             r_s_valid;
  logic             r_in_ready;
  logic [1:0]       r_count;

  logic [ENT_W-1:0] w_in;
  logic [ENT_W-1:0] w_h_nxt;
  logic [ENT_W-1:0] w_s_nxt;
  logic             w_hv_nxt;
  logic             w_sv_nxt;
  logic             w_acc;
  logic             w_pop;

  assign w_in  = {WB, M, ALUOut, RegRD, WriteDataIn};
  assign w_acc = in_valid & r_in_ready & ~flush;
  assign w_pop = r_h_valid & out_ready;

  // Next-state for head/skid; flush overrides every move.
  always_comb begin
    w_h_nxt  = r_h;
    w_s_nxt  = r_s;
    w_hv_nxt = r_h_valid;
    w_sv_nxt = r_s_valid;
    if (flush) begin
      w_hv_nxt = 1'b0;
      w_sv_nxt = 1'b0;
    end else if (!r_h_valid) begin
      if (w_acc) begin
        w_h_nxt  = w_in;
        w_hv_nxt = 1'b1;
      end
    end else if (w_pop) begin
      if (r_s_valid) begin
        w_h_nxt  = r_s;
        w_sv_nxt = 1'b0;
      end else if (w_acc) begin
        w_h_nxt  = w_in;
      end else begin
        w_hv_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_s_nxt  = w_in;
      w_sv_nxt = 1'b1;
    end
    // Bubbles carry zero control so MEM/WB never see stale writes; data holds.
    if (!w_hv_nxt) begin
      w_h_nxt[ENT_W-1:M_LSB] = '0;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_h        <= '0;
      r_s        <= '0;
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_count    <= 2'd0;
    end else begin
      r_h        <= w_h_nxt;
      r_s        <= w_s_nxt;
      r_h_valid  <= w_hv_nxt;
      r_s_valid  <= w_sv_nxt;
      r_in_ready <= ~w_sv_nxt;
      r_count    <= 2'({1'b0, w_hv_nxt} + {1'b0, w_sv_nxt});
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_h_valid;
  assign count        = r_count;
  assign WBreg        = r_h[WB_LSB +: WB_W];
  assign Mreg         = r_h[M_LSB +: M_W];
  assign ALUreg       = r_h[ALU_LSB +: DATA_W];
  assign RegRDreg     = r_h[RD_LSB +: REG_W];
  assign WriteDataOut = r_h[WD_LSB +: DATA_W];

  // WB is zero whenever H is empty, so RegWrite alone qualifies the tap.
  assign fwd_valid    = r_h[WB_LSB];
  assign fwd_rd       = r_h[RD_LSB +: REG_W];
  assign fwd_data     = r_h[ALU_LSB +: DATA_W];

endmodule

// File: tb/tb_exmem_skid.sv
// Bench for exmem_skid: a default-width and a 64/6-bit instance share control
// stimulus and are compared every cycle against a queue-based reference.
module tb_exmem_skid;

  logic        clock = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  in_wb;
  logic [2:0]  in_m;
  logic [63:0] in_alu, in_wd;
  logic [5:0]  in_rd;

  logic        a_in_ready, a_out_valid, a_fwd_valid;
  logic [1:0]  a_wb, a_count;
  logic [2:0]  a_m;
  logic [31:0] a_alu, a_wd, a_fwd_data;
  logic [4:0]  a_rd, a_fwd_rd;

  logic        b_in_ready, b_out_valid, b_fwd_valid;
  logic [1:0]  b_wb, b_count;
  logic [2:0]  b_m;
  logic [63:0] b_alu, b_wd, b_fwd_data;
  logic [5:0]  b_rd, b_fwd_rd;

  always #5 clock = ~clock;

  exmem_skid dut32 (
    .clock(clock), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .WB(in_wb), .M(in_m), .ALUOut(in_alu[31:0]), .RegRD(in_rd[4:0]), .WriteDataIn(in_wd[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .WBreg(a_wb), .Mreg(a_m), .ALUreg(a_alu),
    .RegRDreg(a_rd), .WriteDataOut(a_wd), .count(a_count), .fwd_valid(a_fwd_valid),
    .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data)
  );

  exmem_skid #(.DATA_W(64), .REG_W(6)) dut64 (
    .clock(clock), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .WB(in_wb), .M(in_m), .ALUOut(in_alu), .RegRD(in_rd), .WriteDataIn(in_wd),
    .out_valid(b_out_valid), .out_ready(out_ready), .WBreg(b_wb), .Mreg(b_m), .ALUreg(b_alu),
    .RegRDreg(b_rd), .WriteDataOut(b_wd), .count(b_count), .fwd_valid(b_fwd_valid),
    .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [63:0] alu;
    logic [5:0]  rd;
    logic [63:0] wd;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q.delete();
    last = '0;
  endfunction

  // Queue of at most two entries; head data persists once the queue empties.
  function automatic void model_step();
    bit   acc, pop;
    ent_t e;
    if (!rst) begin
      model_clear();
      return;
    end
    acc = in_valid && (q.size() < 2) && !flush;
    pop = (q.size() > 0) && out_ready;
    e   = '{wb: in_wb, m: in_m, alu: in_alu, rd: in_rd, wd: in_wd};
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
  endfunction

  task automatic compare_all();
    logic       ev, efv;
    logic [1:0] ewb;
    logic [2:0] em;
    ev  = q.size() > 0;
    ewb = ev ? q[0].wb : 2'b00;
    em  = ev ? q[0].m  : 3'b000;
    efv = ev & ewb[0];
    check("d32.out_valid", 64'(a_out_valid), 64'(ev));
    check("d32.in_ready",  64'(a_in_ready),  64'(q.size() < 2));
    check("d32.count",     64'(a_count),     64'(q.size()));
    check("d32.WBreg",     64'(a_wb),        64'(ewb));
    check("d32.Mreg",      64'(a_m),         64'(em));
    check("d32.ALUreg",    64'(a_alu),       64'(last.alu[31:0]));
    check("d32.RegRDreg",  64'(a_rd),        64'(last.rd[4:0]));
    check("d32.WDout",     64'(a_wd),        64'(last.wd[31:0]));
    check("d32.fwd_valid", 64'(a_fwd_valid), 64'(efv));
    check("d32.fwd_rd",    64'(a_fwd_rd),    64'(last.rd[4:0]));
    check("d32.fwd_data",  64'(a_fwd_data),  64'(last.alu[31:0]));
    check("d64.out_valid", 64'(b_out_valid), 64'(ev));
    check("d64.in_ready",  64'(b_in_ready),  64'(q.size() < 2));
    check("d64.count",     64'(b_count),     64'(q.size()));
    check("d64.WBreg",     64'(b_wb),        64'(ewb));
    check("d64.Mreg",      64'(b_m),         64'(em));
    check("d64.ALUreg",    b_alu,            last.alu);
    check("d64.RegRDreg",  64'(b_rd),        64'(last.rd));
    check("d64.WDout",     b_wd,             last.wd);
    check("d64.fwd_valid", 64'(b_fwd_valid), 64'(efv));
    check("d64.fwd_rd",    64'(b_fwd_rd),    64'(last.rd));
    check("d64.fwd_data",  b_fwd_data,       last.alu);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [63:0] alu,
                       input logic [5:0] rd);
    in_valid = v;
    in_wb    = wb;
    in_m     = 3'($urandom);
    in_alu   = alu;
    in_rd    = rd;
    in_wd    = {$urandom, $urandom};
  endtask

  task automatic stall_scenario(input logic [63:0] base);
    out_ready = 1'b0;
    drive(1'b1, 2'b01, base ^ 64'hA, 6'd10); tick();
    drive(1'b1, 2'b01, base ^ 64'hB, 6'd11); tick();
    drive(1'b1, 2'b01, base ^ 64'hC, 6'd12); tick(); // held: in_ready is 0
    tick();
    out_ready = 1'b1;
    tick(); tick();                                  // A out, then B out with C accepted
    in_valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 64'd0, 6'd0);
    model_clear();
    @(negedge clock);
    compare_all();
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-stream
    drive(1'b1, 2'b11, 64'hDEAD, 6'd9); tick(); tick();
    #1 rst = 1'b0;
    model_clear();
    #1 compare_all();
    @(negedge clock);
    tick();
    rst = 1'b1;
    drive(1'b1, 2'b01, 64'h1234, 6'd7); tick();
    in_valid = 1'b0; out_ready = 1'b1; tick(); tick();

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b01, 64'(i), 6'(i)); tick();
    end
    in_valid = 1'b0; tick(); tick();

    // Stall, default data and a wide bit pattern
    stall_scenario(64'h0);
    stall_scenario(64'hFFFF_0000_FFFF_0000);

    // Flush with H and S full, pop and new input in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 64'h1, 6'd1); tick();
    drive(1'b1, 2'b11, 64'h2, 6'd2); tick();
    out_ready = 1'b1; flush = 1'b1;
    drive(1'b1, 2'b11, 64'hD, 6'd13); tick();
    flush = 1'b0; in_valid = 1'b0; tick(); tick();

    // Bubble / forwarding tap
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 64'h44, 6'd3); tick();
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 64'h55, 6'd3); tick();
    in_valid = 1'b0; tick(); tick();

    // Randomized traffic, occasional flush and asynchronous reset
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 9) < 7), 2'($urandom), {$urandom, $urandom}, 6'($urandom));
      out_ready = 1'($urandom_range(0, 9) < 6);
      flush     = 1'($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b0;
        model_clear();
        #1 compare_all();
      end else begin
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exmem_skid.md
# exmem_skid

Parametrised EX/MEM pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It carries the WB/M control fields, ALU result, destination register and store data from EX to MEM, and supports backpressure from MEM, pipeline flush and bubble insertion. It also exports a forwarding tap for the hazard unit. It replaces the fixed-width, always-advancing EX/MEM latch.

## Interface
- `DATA_W`, default 32: width of `ALUOut`/`WriteDataIn` and their registered copies.
- `REG_W`, default 5: destination register index width.
- `WB_W`, default 2: WB control width; bit 0 is RegWrite.
- `M_W`, default 3: M control width.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0; takes effect immediately, released synchronously to `clock` by the system).
- `flush`  in  1  synchronous flush; discards all held entries.
- `in_valid`  in  1  EX offers an entry.
- `in_ready`  out  1  stage can accept an entry.
- `WB`  in  `WB_W`  WB control from EX.
- `M`  in  `M_W`  M control from EX.
- `ALUOut`  in  `DATA_W`  ALU result.
- `RegRD`  in  `REG_W`  destination register.
- `WriteDataIn`  in  `DATA_W`  store data.
- `out_valid`  out  1  head entry valid toward MEM.
- `out_ready`  in  1  MEM accepts the head entry.
- `WBreg`, `Mreg`, `ALUreg`, `RegRDreg`, `WriteDataOut`  out  as inputs  head entry fields.
- `count`  out  2  entries held (0..2).
- `fwd_valid`  out  1  `out_valid & WBreg[0]`.
- `fwd_rd`  out  `REG_W`  equals `RegRDreg`.
- `fwd_data`  out  `DATA_W`  equals `ALUreg`.

## Operation
- Storage: head register H (drives outputs) and skid register S, each with a valid bit. Bit fields of an entry are always moved together.
- `in_ready` = !S.valid, driven from a flop and not from `out_ready` combinationally.
- Accept: `acc = in_valid & in_ready & !flush`.
- Pop: `pop = out_valid & out_ready`.
- Update rules, per cycle, when `flush` = 0:
  - H empty, acc: H ← input.
  - H full, pop, S empty, acc: H ← input.
  - H full, pop, S empty, no acc: H.valid ← 0.
  - H full, pop, S full: H ← S, S.valid ← 0. No acc is possible because `in_ready` = 0.
  - H full, no pop, acc: S ← input, so `in_ready` falls next cycle.
  - H full, no pop, no acc: hold.
- Ordering is strictly FIFO; no entry is lost or duplicated.
- Flush (`flush` = 1):
  - H.valid and S.valid clear at the edge.
  - The input that cycle is dropped.
  - A pop in the same cycle still completes; MEM consumes H before the clear.
  - `flush` overrides every update rule above.
- Bubble rule: when `out_valid` = 0, `WBreg` and `Mreg` read 0. `ALUreg`, `RegRDreg` and `WriteDataOut` hold their last value.
- `count` = H.valid + S.valid.
- Reset, while `rst` = 0:
  - H.valid, S.valid = 0.
  - All data fields = 0.
  - `out_valid` = 0, `in_ready` = 1, `count` = 0, `fwd_valid` = 0.
  - Reset mid-transfer discards all held entries.

## Timing
- Latency: one cycle from accept into an empty stage to `out_valid` = 1.
- Throughput: one entry per cycle with `out_ready` held at 1; S is never used in that case.
- Backpressure: after `out_ready` falls, one more entry can be absorbed (into S). `in_ready` drops in the cycle after S fills.
- Recovery: `in_ready` returns to 1 in the cycle after the pop that drains S.
- After flush, the next cycle has `out_valid` = 0, `count` = 0, `in_ready` = 1.
- The forwarding tap is registered state only, with no combinational path from inputs.

## Test plan
- Reset: `rst` = 0 mid-stream → `out_valid` = 0, `count` = 0, `in_ready` = 1, all outputs 0. Release `rst`, then accept ALUOut = 0x1234, RegRD = 7, WB = 2'b01 → next cycle ALUreg = 0x1234, RegRDreg = 7, fwd_valid = 1.
- Streaming: `out_ready` = 1, 8 back-to-back entries with ALUOut = 1..8 → outputs 1..8 on consecutive cycles; `count` never exceeds 1.
- Stall: `out_ready` = 0 while feeding A = 0xA, B = 0xB, C = 0xC.
  - A goes to H, B to S, `count` = 2.
  - `in_ready` = 0, so C is held by EX.
  - Raising `out_ready` outputs A, B, C in order.
- Flush: `count` = 2 with `out_ready` = 1, assert `flush` together with `in_valid` (0xD).
  - H drains that cycle.
  - Next cycle `out_valid` = 0, `count` = 0, `WBreg` = `Mreg` = 0.
  - 0xD never appears.
- Bubble/forward: accept WB = 2'b00, RegRD = 3 → fwd_valid = 0. Accept WB = 2'b11, RegRD = 3, ALUOut = 0x55 → fwd_valid = 1, fwd_rd = 3, fwd_data = 0x55.
- Parameters: DATA_W = 64, REG_W = 6 instance; repeat the stall scenario with ALUOut = 0xFFFF_0000_FFFF_0000 → values preserved bit-exact.
